// File: rtl/common_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count; DEPTH need not be a power of two.
// Optional sticky overflow/underflow outputs are enabled by defining COMMON_SYNC_FIFO_ERR_FLAGS_EN.
module common_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int DSIZE = 8
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic [DSIZE-1:0]           wdata,
  input  logic                       wr_en,
  output logic [DSIZE-1:0]           rdata,
  input  logic                       rd_en,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                       overflow,
  output logic                       underflow
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_accept;
  logic             rd_accept;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Flags come from registered count only, so wr_en/rd_en never reach an output combinationally.
  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Forcing 0 while empty gives a clean rdata during and after reset without clearing storage.
  assign rdata = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_accept) wr_ptr <= next_ptr(wr_ptr);
      if (rd_accept) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_accept, rd_accept})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; resetting the pointers and count already discards every stored word.
  always_ff @(posedge clock) begin
    if (wr_accept) mem[wr_ptr] <= wdata;
  end

`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_common_sync_fifo.sv
// Self-checking bench for common_sync_fifo at DEPTH=6: vector table for fill/drain plus
// hand sequences for wrap-around streaming, mid-operation reset and write-while-full.
module tb_common_sync_fifo;

  localparam int DEPTH = 6;
  localparam int DSIZE = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock = 1'b0;
  logic             rst_n;
  logic [DSIZE-1:0] wdata;
  logic             wr_en;
  logic [DSIZE-1:0] rdata;
  logic             rd_en;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
  logic             overflow;
  logic             underflow;
`endif

  common_sync_fifo #(.DEPTH(DEPTH), .DSIZE(DSIZE)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .wdata     (wdata),
    .wr_en     (wr_en),
    .rdata     (rdata),
    .rd_en     (rd_en),
    .count     (count),
    .empty     (empty),
    .full      (full)
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic             w;
    logic             r;
    logic [DSIZE-1:0] d;
    logic [DSIZE-1:0] exp_rdata;
    logic [CW-1:0]    exp_count;
    logic             exp_empty;
    logic             exp_full;
  } vec_t;

  vec_t             vecs[15];
  logic [DSIZE-1:0] model[$];
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus; outputs are then stable 1 ns after the edge.
  task automatic cycle(input logic w, input logic r, input logic [DSIZE-1:0] d);
    wr_en = w;
    rd_en = r;
    wdata = d;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            w     r     d      rdata  count empty full
    vecs[0]  = '{1'b1, 1'b0, 8'h11, 8'h11, 3'd1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'h22, 8'h11, 3'd2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h33, 8'h11, 3'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h44, 8'h11, 3'd4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h55, 8'h11, 3'd5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h66, 8'h11, 3'd6, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 8'h77, 8'h11, 3'd6, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'h00, 8'h22, 3'd5, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 8'h00, 8'h33, 3'd4, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 8'h00, 8'h44, 3'd3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 8'h00, 8'h55, 3'd2, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 8'h00, 8'h66, 3'd1, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 8'hA5, 8'hA5, 3'd1, 1'b0, 1'b0};

    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset empty", 32'(empty), 32'd1);
    check("reset full",  32'(full),  32'd0);
    check("reset count", 32'(count), 32'd0);
    check("reset rdata", 32'(rdata), 32'd0);
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
    check("reset overflow",  32'(overflow),  32'd0);
    check("reset underflow", 32'(underflow), 32'd0);
`endif
    @(negedge clock);
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, 8'h00);
    check("idle empty", 32'(empty), 32'd1);
    check("idle full",  32'(full),  32'd0);
    check("idle count", 32'(count), 32'd0);
    check("idle rdata", 32'(rdata), 32'd0);

    // Fill to full, overfill, drain, overdrain, then write+read while empty.
    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].w, vecs[i].r, vecs[i].d);
      if (!vecs[i].exp_empty)
        check($sformatf("vec%0d rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d full", i),  32'(full),  32'(vecs[i].exp_full));
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
      if (i == 5) check("overflow before drop", 32'(overflow), 32'd0);
      if (i == 6) check("overflow after drop",  32'(overflow), 32'd1);
      if (i == 12) check("underflow before ignore", 32'(underflow), 32'd0);
      if (i == 13) check("underflow after ignore",  32'(underflow), 32'd1);
`endif
    end

    // Streaming at count=3: simultaneous read/write for 10 cycles wraps both pointers.
    model.delete();
    model.push_back(8'hA5);
    cycle(1'b1, 1'b0, 8'hC1); model.push_back(8'hC1);
    cycle(1'b1, 1'b0, 8'hC2); model.push_back(8'hC2);
    check("stream start count", 32'(count), 32'd3);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 8'hD0 + 8'(i));
      void'(model.pop_front());
      model.push_back(8'hD0 + 8'(i));
      check($sformatf("stream%0d rdata", i), 32'(rdata), 32'(model[0]));
      check($sformatf("stream%0d count", i), 32'(count), 32'd3);
    end

    // Mid-operation asynchronous reset at count=4.
    cycle(1'b1, 1'b0, 8'hE0);
    check("pre-reset count", 32'(count), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset empty", 32'(empty), 32'd1);
    check("async reset count", 32'(count), 32'd0);
    check("async reset full",  32'(full),  32'd0);
    check("async reset rdata", 32'(rdata), 32'd0);
`ifdef COMMON_SYNC_FIFO_ERR_FLAGS_EN
    check("async reset overflow",  32'(overflow),  32'd0);
    check("async reset underflow", 32'(underflow), 32'd0);
`endif
    #2;
    rst_n = 1'b1;
    cycle(1'b1, 1'b0, 8'h5A);
    check("post-reset rdata", 32'(rdata), 32'h5A);
    check("post-reset count", 32'(count), 32'd1);
    check("post-reset empty", 32'(empty), 32'd0);

    // Write while full with rd_en: head pops, write is dropped.
    model.delete();
    model.push_back(8'h5A);
    for (int i = 1; i <= 5; i++) begin
      cycle(1'b1, 1'b0, 8'(i));
      model.push_back(8'(i));
    end
    check("refill full", 32'(full), 32'd1);
    cycle(1'b1, 1'b1, 8'h99);
    void'(model.pop_front());
    check("full wr+rd count", 32'(count), 32'd5);
    check("full wr+rd full",  32'(full),  32'd0);
    check("full wr+rd rdata", 32'(rdata), 32'h01);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("drain%0d rdata", i), 32'(rdata), 32'(model[0]));
      cycle(1'b0, 1'b1, 8'h00);
      void'(model.pop_front());
    end
    check("drain empty", 32'(empty), 32'd1);
    check("drain count", 32'(count), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
